hb_wb_gateway: RTL and testbench

HB_WB_GATEWAY -- requirements
Module: hb_wb_gateway

---
 rtl/hb_wb_gateway_pkg.sv | 18 +
 rtl/hb_wb_gateway_sync.sv | 30 +++
 rtl/hb_wb_gateway.sv | 141 ++++++++++++++
 tb/tb_hb_wb_gateway.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_wb_gateway_pkg.sv
// Shared types and constants for the host-bus to Wishbone gateway.
// State encodings, default widths and the bus-error read pattern.
package hb_wb_gateway_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int MAX_DATA_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB_REQ  = 2'd1,
        HB_HOLD = 2'd2
    } gw_state_e;

    localparam logic [MAX_DATA_WIDTH-1:0] BUS_ERR_DATA = '1;

endpackage

// File: rtl/hb_wb_gateway_sync.sv
// hb_sync: two-flop synchronizer for an asynchronous host request,
// plus a third flop that yields a one-cycle rising-edge pulse.
module hb_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/hb_wb_gateway.sv
// Asynchronous host strobe bus to Wishbone master gateway.
// Optional Wishbone wait timeout: define HB_WB_TIMEOUT_EN.
module hb_wb_gateway
    import hb_wb_gateway_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hb_cs_n,
    input  logic                  hb_rd_n,
    input  logic                  hb_wr_n,
    input  logic [ADDR_WIDTH-1:0] hb_addr,
    input  logic [DATA_WIDTH-1:0] hb_wrData,
    output logic [DATA_WIDTH-1:0] hb_rdData,
    output logic                  hb_ready,
    output logic                  hb_err,
    output logic                  wb_cycle,
    output logic                  wb_strobe,
    output logic                  wb_write,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_wrData,
    input  logic [DATA_WIDTH-1:0] wb_rdData,
    input  logic                  wb_ack
);

    logic      req_rd;
    logic      req_wr;
    logic      rd_lvl;
    logic      rd_rise;
    logic      wr_lvl;
    logic      wr_rise;
    logic      req_lvl;
    logic      err_hold;
    gw_state_e state;

    assign req_rd = ~hb_cs_n & ~hb_rd_n;
    assign req_wr = ~hb_cs_n & ~hb_wr_n;

    hb_sync u_rd_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (req_rd),
        .level    (rd_lvl),
        .rise     (rd_rise)
    );

    hb_sync u_wr_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (req_wr),
        .level    (wr_lvl),
        .rise     (wr_rise)
    );

    // The request that opened the transaction decides when the host lets go
    assign req_lvl = wb_write ? wr_lvl : rd_lvl;

`ifdef HB_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err_hold  <= 1'b0;
            hb_rdData <= '0;
            hb_ready  <= 1'b0;
            hb_err    <= 1'b0;
            wb_cycle  <= 1'b0;
            wb_strobe <= 1'b0;
            wb_write  <= 1'b0;
            wb_addr   <= '0;
            wb_wrData <= '0;
`ifdef HB_WB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_rise || wr_rise) begin
                        if (rd_lvl && wr_lvl) begin
                            hb_err   <= 1'b1;
                            err_hold <= 1'b1;
                            state    <= HB_HOLD;
                        end else begin
                            wb_addr   <= hb_addr;
                            wb_wrData <= hb_wrData;
                            wb_write  <= wr_rise;
                            wb_cycle  <= 1'b1;
                            wb_strobe <= 1'b1;
                            state     <= WB_REQ;
`ifdef HB_WB_TIMEOUT_EN
                            to_cnt    <= '0;
`endif
                        end
                    end
                end
                WB_REQ: begin
                    if (wb_ack) begin
                        wb_cycle  <= 1'b0;
                        wb_strobe <= 1'b0;
                        if (!wb_write) begin
                            hb_rdData <= wb_rdData;
                        end
                        hb_ready <= req_lvl;
                        state    <= req_lvl ? HB_HOLD : IDLE;
`ifdef HB_WB_TIMEOUT_EN
                    end else if (to_cnt == CNT_LAST) begin
                        wb_cycle  <= 1'b0;
                        wb_strobe <= 1'b0;
                        hb_rdData <= BUS_ERR_DATA[DATA_WIDTH-1:0];
                        hb_err    <= 1'b1;
                        hb_ready  <= req_lvl;
                        state     <= req_lvl ? HB_HOLD : IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                HB_HOLD: begin
                    // A collision waits for both strobes to clear
                    if (err_hold ? !(rd_lvl || wr_lvl) : !req_lvl) begin
                        hb_ready <= 1'b0;
                        err_hold <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hb_wb_gateway.sv
// Self-checking bench for hb_wb_gateway with randomized host transfers
// and a simple transaction-level expectation model.
module tb_hb_wb_gateway;

    logic        clk;
    logic        rst;
    logic        hb_cs_n;
    logic        hb_rd_n;
    logic        hb_wr_n;
    logic [15:0] hb_addr;
    logic [15:0] hb_wrData;
    logic [15:0] hb_rdData;
    logic        hb_ready;
    logic        hb_err;
    logic        wb_cycle;
    logic        wb_strobe;
    logic        wb_write;
    logic [15:0] wb_addr;
    logic [15:0] wb_wrData;
    logic [15:0] wb_rdData;
    logic        wb_ack;

    int checks;
    int errors;

    // Model: last value a read (or timeout) handed to the host
    logic [15:0] exp_rd;

    hb_wb_gateway #(
        .DATA_WIDTH     (16),
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hb_cs_n   (hb_cs_n),
        .hb_rd_n   (hb_rd_n),
        .hb_wr_n   (hb_wr_n),
        .hb_addr   (hb_addr),
        .hb_wrData (hb_wrData),
        .hb_rdData (hb_rdData),
        .hb_ready  (hb_ready),
        .hb_err    (hb_err),
        .wb_cycle  (wb_cycle),
        .wb_strobe (wb_strobe),
        .wb_write  (wb_write),
        .wb_addr   (wb_addr),
        .wb_wrData (wb_wrData),
        .wb_rdData (wb_rdData),
        .wb_ack    (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic release_host();
        hb_cs_n = 1'b1;
        hb_rd_n = 1'b1;
        hb_wr_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Host transfer against a Wishbone slave that acks after dly cycles
    task automatic xfer(input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rdv,
                        input int dly, input bit drop, input string tag);
        int lat;
        bit seen;
        bit bad;
        int rel;
        @(negedge clk);
        hb_addr   = a;
        hb_wrData = d;
        hb_cs_n   = 1'b0;
        if (wr) hb_wr_n = 1'b0;
        else    hb_rd_n = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (wb_cycle === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != 3) begin
            errors++;
            $display("FAIL %s start latency got %0d want 3 seen=%0d",
                     tag, lat, seen);
            release_host();
            idle(30);
            return;
        end
        if (drop) release_host();
        bad = 1'b0;
        for (int k = 0; k <= dly; k++) begin
            if ({wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData, hb_ready}
                !== {1'b1, 1'b1, wr, a, d, 1'b0}) bad = 1'b1;
            if (k == dly) begin
                wb_ack    = 1'b1;
                wb_rdData = rdv;
            end
            @(negedge clk);
        end
        wb_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s wb request fields unstable or wrong want a=%h d=%h w=%0d",
                     tag, a, d, wr);
        end
        if (!wr) exp_rd = rdv;
        checks++;
        if ({wb_cycle, wb_strobe, hb_ready, hb_rdData}
            !== {1'b0, 1'b0, !drop, exp_rd}) begin
            errors++;
            $display("FAIL %s after ack got cyc=%b stb=%b rdy=%b rd=%h want 0 0 %b %h",
                     tag, wb_cycle, wb_strobe, hb_ready, hb_rdData, !drop, exp_rd);
        end
        bad = 1'b0;
        if (!drop) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (hb_ready !== 1'b1 || wb_cycle !== 1'b0) bad = 1'b1;
            end
            release_host();
            rel = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                rel++;
                if (wb_cycle !== 1'b0) bad = 1'b1;
                if (hb_ready === 1'b0) break;
            end
            checks++;
            if (rel > 3 || hb_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready release got %0d clk want <=3", tag, rel);
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (hb_ready !== 1'b0 || wb_cycle !== 1'b0) bad = 1'b1;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s hold phase ready/cycle wrong drop=%0d", tag, drop);
        end
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        release_host();
        hb_addr   = '0;
        hb_wrData = '0;
        wb_rdData = '0;
        wb_ack    = 1'b0;
        idle(3);
        rst = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        checks++;
        if ({wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
             hb_rdData, hb_ready, hb_err} !== '0) begin
            errors++;
            $display("FAIL reset_state outputs nonzero rd=%h rdy=%b err=%b cyc=%b",
                     hb_rdData, hb_ready, hb_err, wb_cycle);
        end
    endtask

    task automatic test_write();
        xfer(1'b1, 16'h1234, 16'hBEEF, 16'h0000, 2, 1'b0, "write_1234");
    endtask

    task automatic test_read();
        xfer(1'b0, 16'h0010, 16'h0000, 16'h5A5A, 1, 1'b0, "read_0010");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            xfer(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, 4)), 1'b0, "random");
        end
    endtask

    task automatic test_drop();
        xfer(1'b0, 16'h0777, 16'h0000, 16'hC3C3, 5, 1'b1, "drop_read");
        xfer(1'b1, 16'h0778, 16'h1111, 16'h0000, 6, 1'b1, "drop_write");
    endtask

    task automatic test_ack_outside();
        @(negedge clk);
        wb_rdData = 16'hDEAD;
        wb_ack    = 1'b1;
        idle(2);
        wb_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_cycle, hb_ready, hb_rdData} !== {1'b0, 1'b0, exp_rd}) begin
            errors++;
            $display("FAIL stray_ack got cyc=%b rdy=%b rd=%h want 0 0 %h",
                     wb_cycle, hb_ready, hb_rdData, exp_rd);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        hb_addr = 16'h0040;
        hb_cs_n = 1'b0;
        hb_rd_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (wb_cycle === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        release_host();
        @(negedge clk);
        checks++;
        if (!seen || {wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
                      hb_rdData, hb_ready, hb_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid seen=%0d cyc=%b stb=%b rd=%h want all 0",
                     seen, wb_cycle, wb_strobe, hb_rdData);
        end
        rst = 1'b0;
        exp_rd = '0;
        idle(6);
        checks++;
        if (wb_cycle !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_retry cyc=%b want 0", wb_cycle);
        end
        xfer(1'b0, 16'h0002, 16'h0000, 16'h2468, 3, 1'b0, "read_after_reset");
    endtask

`ifdef HB_WB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        int n;
        @(negedge clk);
        hb_addr = 16'h0100;
        hb_cs_n = 1'b0;
        hb_rd_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (wb_cycle === 1'b1) seen = 1'b1;
        end
        n = 0;
        while (seen && wb_cycle === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL timeout_len got %0d cycles want 8", n);
        end
        exp_rd = 16'hFFFF;
        checks++;
        if ({hb_rdData, hb_err, hb_ready} !== {16'hFFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL timeout_result rd=%h err=%b rdy=%b want ffff 1 1",
                     hb_rdData, hb_err, hb_ready);
        end
        release_host();
        idle(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = '0;
        idle(3);
    endtask
`endif

    task automatic test_both();
        bit bad;
        @(negedge clk);
        hb_addr = 16'h0BAD;
        hb_cs_n = 1'b0;
        hb_rd_n = 1'b0;
        hb_wr_n = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb_cycle !== 1'b0 || wb_strobe !== 1'b0 || hb_ready !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad || hb_err !== 1'b1) begin
            errors++;
            $display("FAIL collision bad=%0d err=%b want err=1 no cycle no ready",
                     bad, hb_err);
        end
        release_host();
        idle(6);
        checks++;
        if ({hb_err, hb_ready, wb_cycle} !== 3'b100) begin
            errors++;
            $display("FAIL collision_sticky err=%b rdy=%b cyc=%b want 1 0 0",
                     hb_err, hb_ready, wb_cycle);
        end
        xfer(1'b0, 16'h0042, 16'h0000, 16'h9999, 2, 1'b0, "read_after_err");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write();
        test_read();
        test_random();
        test_drop();
        test_ack_outside();
        test_reset_mid();
`ifdef HB_WB_TIMEOUT_EN
        test_timeout();
`endif
        test_both();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
